// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: steps the datapath through FETCH, DECODE, EXEC, MEM and WB,
// handshaking with instruction/data memory and retiring each instruction exactly once.
module multicycle_sequencer #(
  parameter int          CNT_W      = 16,
  parameter int          WAIT_LIMIT = 15,
  parameter logic [5:0]  SUB_FUNCT  = 6'b100010
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_load,
  output logic             pc_en,
  output logic             Reg_write,
  output logic             ALU_op,
  output logic             ALU_src,
  output logic             Writeback_src,
  output logic             halted,
  output logic             fault,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    C_NOP   = 2'd0,
    C_RTYPE = 2'd1,
    C_ADDI  = 2'd2,
    C_LOAD  = 2'd3
  } cls_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [7:0] LIMIT    = 8'(WAIT_LIMIT);

  state_t           r_state;
  cls_t             r_cls;
  logic [7:0]       r_wait;
  logic             r_illegal;
  logic             r_alu_op;
  logic             r_alu_src;
  logic             r_wb_src;
  logic [CNT_W-1:0] r_retired;
  logic             w_wait_hit;

  // r_wait holds the cycles already spent waiting; the current cycle is r_wait+1.
  assign w_wait_hit = ((r_wait + 8'd1) == LIMIT);

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_FETCH;
      r_cls     <= C_NOP;
      r_wait    <= 8'd0;
      r_illegal <= 1'b0;
      r_alu_op  <= 1'b0;
      r_alu_src <= 1'b0;
      r_wb_src  <= 1'b0;
      r_retired <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack)        r_state <= S_DECODE;
          else if (w_wait_hit) r_state <= S_FAULT;
          else                 r_wait  <= r_wait + 8'd1;
        end
        S_DECODE: begin
          r_state <= S_EXEC;
          case (Opcode)
            OP_RTYPE: begin
              r_cls     <= C_RTYPE;
              r_alu_src <= 1'b0;
              r_wb_src  <= 1'b0;
              r_alu_op  <= (Funct == SUB_FUNCT);
            end
            OP_ADDI: begin
              r_cls     <= C_ADDI;
              r_alu_src <= 1'b1;
              r_wb_src  <= 1'b0;
              r_alu_op  <= 1'b0;
            end
            OP_LOAD: begin
              r_cls     <= C_LOAD;
              r_alu_src <= 1'b1;
              r_wb_src  <= 1'b1;
              r_alu_op  <= 1'b0;
            end
            OP_HALT: r_state <= S_HALT;
            default: begin
              r_cls     <= C_NOP;
              r_illegal <= 1'b1;
              r_alu_src <= 1'b0;
              r_wb_src  <= 1'b0;
              r_alu_op  <= 1'b0;
            end
          endcase
        end
        S_EXEC: begin
          r_wait <= 8'd0;
          if (r_cls == C_LOAD) r_state <= S_MEM;
          else                 r_state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ack)        r_state <= S_WB;
          else if (w_wait_hit) r_state <= S_FAULT;
          else                 r_wait  <= r_wait + 8'd1;
        end
        S_WB: begin
          r_retired <= r_retired + CNT_W'(1);
          r_wait    <= 8'd0;
          r_state   <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_FAULT;
      endcase
    end
  end

  // Reset forces FETCH, so only the FETCH strobes need explicit gating by Reset.
  assign imem_req      = Reset & (r_state == S_FETCH);
  assign ir_load       = imem_req & imem_ack;
  assign dmem_req      = (r_state == S_MEM);
  assign pc_en         = (r_state == S_WB);
  assign Reg_write     = (r_state == S_WB) & (r_cls != C_NOP);
  assign ALU_op        = r_alu_op;
  assign ALU_src       = r_alu_src;
  assign Writeback_src = r_wb_src;
  assign halted        = (r_state == S_HALT) | (r_state == S_FAULT);
  assign fault         = (r_state == S_FAULT);
  assign illegal       = r_illegal;
  assign retired_count = r_retired;
  assign state         = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: instruction sequencing, held controls,
// wait timeouts, HALT/FAULT, mid-instruction reset and counter wrap (narrow second instance).
module tb_multicycle_sequencer;

  logic        clk;
  logic        Reset;
  logic [5:0]  Opcode, Funct;
  logic        imem_ack, dmem_ack;
  logic        imem_req, dmem_req, ir_load, pc_en, Reg_write;
  logic        ALU_op, ALU_src, Writeback_src, halted, fault, illegal;
  logic [15:0] retired_count;
  logic [2:0]  state;

  logic        imem_req_w, dmem_req_w, ir_load_w, pc_en_w, Reg_write_w;
  logic        ALU_op_w, ALU_src_w, Writeback_src_w, halted_w, fault_w, illegal_w;
  logic [2:0]  retired_count_w;
  logic [2:0]  state_w;

  int n_tests = 0;
  int n_fail  = 0;

  int r_cycles, rw_cnt, rw_cyc, pc_cnt, pc_cyc, dreq_cnt, ireq_cnt, ir_cnt;
  logic [2:0] seq [0:31];
  logic held_ok, op_ex, src_ex, wbs_ex, op_wb, src_wb, wbs_wb;

  multicycle_sequencer #(.CNT_W(16), .WAIT_LIMIT(15), .SUB_FUNCT(6'b100010)) dut (
    .clk(clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_load(ir_load), .pc_en(pc_en),
    .Reg_write(Reg_write), .ALU_op(ALU_op), .ALU_src(ALU_src),
    .Writeback_src(Writeback_src), .halted(halted), .fault(fault), .illegal(illegal),
    .retired_count(retired_count), .state(state)
  );

  multicycle_sequencer #(.CNT_W(3), .WAIT_LIMIT(15), .SUB_FUNCT(6'b100010)) dut_w (
    .clk(clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req_w), .dmem_req(dmem_req_w), .ir_load(ir_load_w), .pc_en(pc_en_w),
    .Reg_write(Reg_write_w), .ALU_op(ALU_op_w), .ALU_src(ALU_src_w),
    .Writeback_src(Writeback_src_w), .halted(halted_w), .fault(fault_w), .illegal(illegal_w),
    .retired_count(retired_count_w), .state(state_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    Reset    = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1 Reset = 1'b1;
  endtask

  // Runs one instruction from FETCH until WB/HALT/FAULT is observed, then steps past that edge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int idly, input int ddly);
    int fcnt, mcnt;
    logic [2:0] st;
    bit done;
    Opcode = op; Funct = fn;
    fcnt = 0; mcnt = 0; done = 0; held_ok = 1'b1;
    r_cycles = 0; rw_cnt = 0; rw_cyc = 0; pc_cnt = 0; pc_cyc = 0;
    dreq_cnt = 0; ireq_cnt = 0; ir_cnt = 0;
    op_ex = 0; src_ex = 0; wbs_ex = 0; op_wb = 0; src_wb = 0; wbs_wb = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      st = state;
      imem_ack = (st == 3'd0) && (fcnt >= idly);
      dmem_ack = (st == 3'd3) && (mcnt >= ddly);
      #1;
      if (c < 32) seq[c] = st;
      r_cycles = c + 1;
      if (Reg_write) begin rw_cnt++; rw_cyc = c + 1; end
      if (pc_en) begin pc_cnt++; pc_cyc = c + 1; end
      if (dmem_req) dreq_cnt++;
      if (imem_req) ireq_cnt++;
      if (ir_load) ir_cnt++;
      if (st == 3'd0) fcnt++;
      if (st == 3'd3) mcnt++;
      if (st == 3'd2) begin op_ex = ALU_op; src_ex = ALU_src; wbs_ex = Writeback_src; end
      if ((st == 3'd3 || st == 3'd4) && ({ALU_op, ALU_src, Writeback_src} !== {op_ex, src_ex, wbs_ex}))
        held_ok = 1'b0;
      if (st == 3'd4) begin op_wb = ALU_op; src_wb = ALU_src; wbs_wb = Writeback_src; end
      if (st == 3'd4 || st == 3'd5 || st == 3'd6) done = 1;
    end
    chk("run_completed", done, 1);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hold_hits, tot;
    Reset = 1'b1; Opcode = 6'd0; Funct = 6'd0; imem_ack = 1'b1; dmem_ack = 1'b1;
    #1 Reset = 1'b0;

    // Reset state: everything low even with acks asserted
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_ir_load", ir_load, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_reg_write", Reg_write, 0);
    chk("rst_ctrl", {ALU_op, ALU_src, Writeback_src}, 0);
    chk("rst_flags", {halted, fault, illegal}, 0);
    chk("rst_retired", retired_count, 0);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk);
    #1 Reset = 1'b1;

    // R-type add
    run_instr(6'b000000, 6'b100000, 0, 0);
    chk("add_cycles", r_cycles, 4);
    chk("add_seq", {seq[0], seq[1], seq[2], seq[3]}, {3'd0, 3'd1, 3'd2, 3'd4});
    chk("add_rw_cnt", rw_cnt, 1);
    chk("add_rw_cyc", rw_cyc, 4);
    chk("add_pc_cnt", pc_cnt, 1);
    chk("add_pc_cyc", pc_cyc, 4);
    chk("add_ir_load", ir_cnt, 1);
    chk("add_ctrl", {op_wb, src_wb, wbs_wb}, 3'b000);
    chk("add_retired", retired_count, 1);
    chk("add_state_after", state, 0);

    // SUB then ADDI
    do_reset();
    run_instr(6'b000000, 6'b100010, 0, 0);
    tot = r_cycles;
    chk("sub_alu_op", op_wb, 1);
    chk("sub_alu_src", src_wb, 0);
    chk("sub_held", held_ok, 1);
    run_instr(6'b001000, 6'b100010, 0, 0);
    tot += r_cycles;
    chk("addi_ctrl", {op_wb, src_wb, wbs_wb}, 3'b010);
    chk("addi_rw_cnt", rw_cnt, 1);
    chk("subaddi_cycles", tot, 8);
    chk("subaddi_retired", retired_count, 2);

    // LOAD with dmem_ack delayed 3 cycles
    do_reset();
    run_instr(6'b100011, 6'b000000, 0, 3);
    chk("ld_cycles", r_cycles, 8);
    chk("ld_dmem_req", dreq_cnt, 4);
    chk("ld_wb_src", {op_wb, src_wb, wbs_wb}, 3'b011);
    chk("ld_held", held_ok, 1);
    chk("ld_rw_cnt", rw_cnt, 1);
    chk("ld_rw_cyc", rw_cyc, 8);
    chk("ld_retired", retired_count, 1);

    // Illegal opcode retires as NOP, then HALT is terminal
    do_reset();
    run_instr(6'b010101, 6'b000000, 0, 0);
    chk("ill_cycles", r_cycles, 4);
    chk("ill_rw_cnt", rw_cnt, 0);
    chk("ill_pc_cnt", pc_cnt, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_retired", retired_count, 1);
    run_instr(6'b111111, 6'b000000, 0, 0);
    chk("halt_cycles", r_cycles, 3);
    chk("halt_pc_cnt", pc_cnt, 0);
    chk("halt_state", state, 5);
    chk("halt_flags", {halted, fault, illegal}, 3'b101);
    hold_hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_ack = 1'b1; dmem_ack = 1'b1;
      #1;
      if (imem_req || pc_en || Reg_write || dmem_req || ir_load || state != 3'd5) hold_hits++;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    chk("halt_quiet_20", hold_hits, 0);
    chk("halt_retired", retired_count, 1);

    // imem_ack withheld -> FAULT after 15 request cycles
    do_reset();
    run_instr(6'b000000, 6'b100000, 99, 0);
    chk("ifault_req_cycles", ireq_cnt, 15);
    chk("ifault_state", state, 6);
    chk("ifault_flags", {halted, fault}, 2'b11);
    chk("ifault_rw", rw_cnt + pc_cnt, 0);
    // ack on the 15th cycle wins over the limit
    do_reset();
    run_instr(6'b000000, 6'b100000, 14, 0);
    chk("iack15_req_cycles", ireq_cnt, 15);
    chk("iack15_cycles", r_cycles, 18);
    chk("iack15_fault", fault, 0);
    chk("iack15_retired", retired_count, 1);
    // dmem_ack withheld -> FAULT after 15 MEM cycles
    do_reset();
    run_instr(6'b100011, 6'b000000, 0, 99);
    chk("dfault_req_cycles", dreq_cnt, 15);
    chk("dfault_state", state, 6);
    chk("dfault_rw", rw_cnt, 0);

    // Reset asserted during MEM
    do_reset();
    run_instr(6'b001000, 6'b000000, 0, 0);
    chk("mrst_pre_retired", retired_count, 1);
    Opcode = 6'b100011;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_ack = (state == 3'd0);
      dmem_ack = 1'b0;
      #1;
      if (state == 3'd3) break;
    end
    chk("mrst_reached_mem", state, 3);
    chk("mrst_ctrl_before", {ALU_src, Writeback_src}, 2'b11);
    imem_ack = 1'b0;
    Reset = 1'b0;
    #1;
    chk("mrst_state", state, 0);
    chk("mrst_strobes", {imem_req, dmem_req, ir_load, pc_en, Reg_write}, 0);
    chk("mrst_ctrl", {ALU_op, ALU_src, Writeback_src}, 0);
    chk("mrst_flags", {halted, fault, illegal}, 0);
    chk("mrst_retired", retired_count, 0);
    @(posedge clk);
    #1 Reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mrst_release_state", state, 0);
    chk("mrst_release_req", imem_req, 1);
    chk("mrst_release_retired", retired_count, 0);

    // Counter wrap on the 3-bit instance
    do_reset();
    for (int i = 0; i < 7; i++) run_instr(6'b001000, 6'b000000, 0, 0);
    chk("wrap_pre_narrow", retired_count_w, 7);
    chk("wrap_pre_wide", retired_count, 7);
    run_instr(6'b001000, 6'b000000, 0, 0);
    chk("wrap_narrow", retired_count_w, 0);
    chk("wrap_wide", retired_count, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
